// File: rtl/roic_lvds_stream_tx.sv
// ----------------------------------------------------------------------------
// roic_lvds_stream_tx
// Transmit end of the ROIC LVDS link. It emits one serial bit per clk, MSB
// first, in fixed DATA_WIDTH-bit words. The word stream is made of:
//   - idle words;
//   - alignment training bursts (PATTERN_1 / PATTERN_2 alternating);
//   - lines (LINE_MARKER followed by NUM_CHANNELS channel words).
// A frame clock and a word strobe accompany the data.
//
// Ports
//   clk          bit clock, one serial bit per rising edge
//   rst_n        asynchronous active-low reset
//   train_start  pulse, request a training burst
//   line_start   pulse, request one line
//   data_in      channel word from the source
//   data_valid   data_in valid (sampled only while data_ready is high)
//   data_ready   word request strobe, transfer = data_ready & data_valid
//   ser_data     serial bit, MSB first
//   fclk_out     frame clock, high for the first half of every word
//   word_strobe  high while the first bit of a word is on the wire
//   busy         a burst/line is running or a start is pending
//   train_done   1-cycle pulse when the last training word is loaded
//   line_done    1-cycle pulse when the last channel word is loaded
//   underrun     sticky, a channel word was missed; cleared by a new line
//   chan_idx     channel index of the data word currently on the wire
// ----------------------------------------------------------------------------
module roic_lvds_stream_tx #(
    parameter int                    DATA_WIDTH   = 24,
    parameter int                    NUM_CHANNELS = 256,
    parameter int                    TRAIN_WORDS  = 16,
    parameter logic [DATA_WIDTH-1:0] PATTERN_1    = 24'hFFF000,
    parameter logic [DATA_WIDTH-1:0] PATTERN_2    = 24'hFF0000,
    parameter logic [DATA_WIDTH-1:0] LINE_MARKER  = 24'hFFFFFF,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = 24'h000000
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  train_start,
    input  logic                                  line_start,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    input  logic                                  data_valid,
    output logic                                  data_ready,
    output logic                                  ser_data,
    output logic                                  fclk_out,
    output logic                                  word_strobe,
    output logic                                  busy,
    output logic                                  train_done,
    output logic                                  line_done,
    output logic                                  underrun,
    output logic [$clog2(NUM_CHANNELS+1)-1:0]     chan_idx
);

    localparam int BW   = $clog2(DATA_WIDTH);
    localparam int CW   = $clog2(NUM_CHANNELS + 1);
    localparam int WMAX = (NUM_CHANNELS > TRAIN_WORDS) ? NUM_CHANNELS : TRAIN_WORDS;
    localparam int WCW  = $clog2(WMAX + 1);

    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]  READY_SET = BW'(DATA_WIDTH - 3);
    localparam logic [BW-1:0]  HALF_BIT  = BW'(DATA_WIDTH / 2);
    localparam logic [WCW-1:0] TW_END    = WCW'(TRAIN_WORDS);
    localparam logic [WCW-1:0] TW_LAST   = WCW'(TRAIN_WORDS - 1);
    localparam logic [WCW-1:0] NC_END    = WCW'(NUM_CHANNELS);
    localparam logic [WCW-1:0] NC_LAST   = WCW'(NUM_CHANNELS - 1);
    localparam logic [WCW-1:0] WC_ZERO   = WCW'(0);
    localparam logic [WCW-1:0] WC_ONE    = WCW'(1);
    localparam logic [CW-1:0]  CH_ZERO   = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_MARKER = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [WCW-1:0]        word_cnt_r, word_cnt_nxt_s;
    logic [CW-1:0]         chan_r, chan_nxt_s;
    logic                  is_data_r, is_data_nxt_s;
    logic                  train_pend_r, train_pend_nxt_s;
    logic                  line_pend_r, line_pend_nxt_s;

    logic                  ser_data_r, fclk_r, word_strobe_r, data_ready_r;
    logic                  busy_r, train_done_r, line_done_r, underrun_r;
    logic [CW-1:0]         chan_idx_r;

    logic                  boundary_s, acc_train_s, acc_line_s;
    logic                  train_done_nxt_s, line_done_nxt_s, data_ready_nxt_s;
    logic [DATA_WIDTH-1:0] load_word_s;

    assign boundary_s = (bit_cnt_r == LAST_BIT);

    // Next-state, next-word and command acceptance logic.
    always_comb begin
        acc_train_s      = 1'b0;
        acc_line_s       = 1'b0;
        train_pend_nxt_s = train_pend_r;
        line_pend_nxt_s  = line_pend_r;
        state_nxt_s      = state_r;
        load_word_s      = IDLE_WORD;
        word_cnt_nxt_s   = word_cnt_r;
        is_data_nxt_s    = is_data_r;
        chan_nxt_s       = chan_r;
        train_done_nxt_s = 1'b0;
        line_done_nxt_s  = 1'b0;

        // Starts are only heard in IDLE with nothing queued; train wins a tie.
        if ((state_r == ST_IDLE) && !train_pend_r && !line_pend_r) begin
            if (train_start) begin
                acc_train_s = 1'b1;
            end else if (line_start) begin
                acc_line_s = 1'b1;
            end else begin
                acc_train_s = 1'b0;
            end
        end else begin
            acc_train_s = 1'b0;
        end

        if (boundary_s) begin
            case (state_r)
                ST_IDLE: begin
                    // A start accepted on the boundary cycle itself goes straight through.
                    train_pend_nxt_s = 1'b0;
                    line_pend_nxt_s  = 1'b0;
                    if (train_pend_r || acc_train_s) begin
                        state_nxt_s    = ST_TRAIN;
                        load_word_s    = PATTERN_1;
                        word_cnt_nxt_s = WC_ONE;
                    end else if (line_pend_r || acc_line_s) begin
                        state_nxt_s    = ST_MARKER;
                        load_word_s    = LINE_MARKER;
                        word_cnt_nxt_s = WC_ZERO;
                    end else begin
                        load_word_s    = IDLE_WORD;
                    end
                end
                ST_TRAIN: begin
                    if (word_cnt_r == TW_END) begin
                        state_nxt_s    = ST_IDLE;
                        load_word_s    = IDLE_WORD;
                        word_cnt_nxt_s = WC_ZERO;
                    end else begin
                        load_word_s      = word_cnt_r[0] ? PATTERN_2 : PATTERN_1;
                        word_cnt_nxt_s   = word_cnt_r + WC_ONE;
                        train_done_nxt_s = (word_cnt_r == TW_LAST);
                    end
                end
                ST_MARKER: begin
                    state_nxt_s     = ST_DATA;
                    load_word_s     = hold_r;
                    word_cnt_nxt_s  = WC_ONE;
                    is_data_nxt_s   = 1'b1;
                    chan_nxt_s      = CH_ZERO;
                    line_done_nxt_s = (NUM_CHANNELS == 1);
                end
                ST_DATA: begin
                    if (word_cnt_r == NC_END) begin
                        state_nxt_s    = ST_IDLE;
                        load_word_s    = IDLE_WORD;
                        word_cnt_nxt_s = WC_ZERO;
                        is_data_nxt_s  = 1'b0;
                        chan_nxt_s     = CH_ZERO;
                    end else begin
                        load_word_s     = hold_r;
                        word_cnt_nxt_s  = word_cnt_r + WC_ONE;
                        chan_nxt_s      = CW'(word_cnt_r);
                        line_done_nxt_s = (word_cnt_r == NC_LAST);
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    load_word_s    = IDLE_WORD;
                    word_cnt_nxt_s = WC_ZERO;
                    is_data_nxt_s  = 1'b0;
                    chan_nxt_s     = CH_ZERO;
                end
            endcase
        end else begin
            if (acc_train_s) begin
                train_pend_nxt_s = 1'b1;
            end else if (acc_line_s) begin
                line_pend_nxt_s = 1'b1;
            end else begin
                train_pend_nxt_s = train_pend_r;
            end
        end

        // Request the next channel word two bits before the boundary, so the
        // source gets one full cycle and the capture settles before the load.
        data_ready_nxt_s = (bit_cnt_r == READY_SET) &&
                           ((state_r == ST_MARKER) ||
                            ((state_r == ST_DATA) && (word_cnt_r != NC_END)));
    end

    // Free-running bit counter and word shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= '0;
            shift_r   <= IDLE_WORD;
        end else begin
            if (boundary_s) begin
                bit_cnt_r <= '0;
                shift_r   <= load_word_s;
            end else begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
                shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sequencer state, word count, pending starts and done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            word_cnt_r   <= '0;
            is_data_r    <= 1'b0;
            chan_r       <= '0;
            train_pend_r <= 1'b0;
            line_pend_r  <= 1'b0;
            train_done_r <= 1'b0;
            line_done_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            word_cnt_r   <= word_cnt_nxt_s;
            is_data_r    <= is_data_nxt_s;
            chan_r       <= chan_nxt_s;
            train_pend_r <= train_pend_nxt_s;
            line_pend_r  <= line_pend_nxt_s;
            train_done_r <= train_done_nxt_s;
            line_done_r  <= line_done_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE) || train_pend_nxt_s || line_pend_nxt_s;
        end
    end

    // Source handshake: request strobe, word capture and sticky underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_ready_r <= 1'b0;
            hold_r       <= IDLE_WORD;
            underrun_r   <= 1'b0;
        end else begin
            data_ready_r <= data_ready_nxt_s;
            if (data_ready_r) begin
                hold_r <= data_valid ? data_in : IDLE_WORD;
            end else begin
                hold_r <= hold_r;
            end
            if (acc_line_s) begin
                underrun_r <= 1'b0;
            end else if (data_ready_r && !data_valid) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    // Output stage: all wire-side signals share one register delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_data_r    <= 1'b0;
            fclk_r        <= 1'b0;
            word_strobe_r <= 1'b0;
            chan_idx_r    <= '0;
        end else begin
            ser_data_r    <= shift_r[DATA_WIDTH-1];
            fclk_r        <= (bit_cnt_r < HALF_BIT);
            word_strobe_r <= (bit_cnt_r == BW'(0));
            chan_idx_r    <= is_data_r ? chan_r : CH_ZERO;
        end
    end

    assign ser_data    = ser_data_r;
    assign fclk_out    = fclk_r;
    assign word_strobe = word_strobe_r;
    assign chan_idx    = chan_idx_r;
    assign data_ready  = data_ready_r;
    assign busy        = busy_r;
    assign train_done  = train_done_r;
    assign line_done   = line_done_r;
    assign underrun    = underrun_r;

endmodule
